// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between imem and dmem, with an
// in-order outstanding-tag FIFO that steers memory responses back to their requester.
package mem_port_arbiter_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
    } mem_pkt_t;
endpackage

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_req_vld,
    output logic             imem_req_rdy,
    input  mem_pkt_t         imem_req,
    output logic             imem_rsp_vld,
    input  logic             imem_rsp_rdy,
    output mem_pkt_t         imem_rsp,
    input  logic             dmem_req_vld,
    output logic             dmem_req_rdy,
    input  mem_pkt_t         dmem_req,
    output logic             dmem_rsp_vld,
    input  logic             dmem_rsp_rdy,
    output mem_pkt_t         dmem_rsp,
    output logic             mem_req_vld,
    input  logic             mem_req_rdy,
    output mem_pkt_t         mem_req,
    input  logic             mem_rsp_vld,
    output logic             mem_rsp_rdy,
    input  mem_pkt_t         mem_rsp,
    output logic [CNT_W-1:0] outstanding_cnt,
    output logic             rsp_err
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

    state_e                     state_q;
    logic                       locked_src_q;
    logic                       last_grant_q;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic [MAX_OUTSTANDING-1:0] tag_q;
    logic                       rsp_err_q;

    logic grant_dmem;
    logic fifo_full, fifo_empty;
    logic head_dmem;
    logic push, pop, err_set;

    assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (cnt_q == '0);
    assign head_dmem  = tag_q[rd_ptr_q];

    // Grant: held while locked, otherwise the lone requester or the one not served last
    always_comb begin
        grant_dmem = 1'b0;
        if (state_q == ST_LOCKED) begin
            grant_dmem = locked_src_q;
        end else if (imem_req_vld && dmem_req_vld) begin
            grant_dmem = ~last_grant_q;
        end else begin
            grant_dmem = dmem_req_vld;
        end
    end

    always_comb begin
        mem_req      = grant_dmem ? dmem_req : imem_req;
        mem_req_vld  = ~rst & ~fifo_full & (grant_dmem ? dmem_req_vld : imem_req_vld);
        imem_req_rdy = ~rst & ~fifo_full & ~grant_dmem & mem_req_rdy;
        dmem_req_rdy = ~rst & ~fifo_full &  grant_dmem & mem_req_rdy;
        push         = mem_req_vld & mem_req_rdy;
    end

    // Responses follow the FIFO head; with nothing outstanding they are drained and flagged
    always_comb begin
        imem_rsp     = mem_rsp;
        dmem_rsp     = mem_rsp;
        imem_rsp_vld = 1'b0;
        dmem_rsp_vld = 1'b0;
        mem_rsp_rdy  = 1'b1;
        err_set      = 1'b0;
        if (!fifo_empty) begin
            imem_rsp_vld = mem_rsp_vld & ~head_dmem;
            dmem_rsp_vld = mem_rsp_vld &  head_dmem;
            mem_rsp_rdy  = head_dmem ? dmem_rsp_rdy : imem_rsp_rdy;
        end else begin
            err_set = mem_rsp_vld & ~rst;
        end
        pop   = ~fifo_empty & mem_rsp_vld & mem_rsp_rdy;
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            locked_src_q <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tag_q        <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_req_vld && !mem_req_rdy) begin
                        state_q      <= ST_LOCKED;
                        locked_src_q <= grant_dmem;
                    end
                end
                ST_LOCKED: begin
                    if (push) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            if (push) begin
                last_grant_q    <= grant_dmem;
                tag_q[wr_ptr_q] <= grant_dmem;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (err_set) rsp_err_q <= 1'b1;
            cnt_q <= cnt_d;
        end
    end

    assign outstanding_cnt = cnt_q;
    assign rsp_err         = rsp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected response destinations are queued
// as requests are accepted and checked as the memory answers.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic       clk;
    logic       rst;
    logic       imem_req_vld, imem_req_rdy, imem_rsp_vld, imem_rsp_rdy;
    logic       dmem_req_vld, dmem_req_rdy, dmem_rsp_vld, dmem_rsp_rdy;
    logic       mem_req_vld, mem_req_rdy, mem_rsp_vld, mem_rsp_rdy;
    mem_pkt_t   imem_req, imem_rsp, dmem_req, dmem_rsp, mem_req, mem_rsp;
    logic [2:0] outstanding_cnt;
    logic       rsp_err;

    int vectors     = 0;
    int miscompares = 0;
    bit exp_q[$];
    bit last_g;

    mem_port_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req_vld(imem_req_vld), .imem_req_rdy(imem_req_rdy), .imem_req(imem_req),
        .imem_rsp_vld(imem_rsp_vld), .imem_rsp_rdy(imem_rsp_rdy), .imem_rsp(imem_rsp),
        .dmem_req_vld(dmem_req_vld), .dmem_req_rdy(dmem_req_rdy), .dmem_req(dmem_req),
        .dmem_rsp_vld(dmem_rsp_vld), .dmem_rsp_rdy(dmem_rsp_rdy), .dmem_rsp(dmem_rsp),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req(mem_req),
        .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdy(mem_rsp_rdy), .mem_rsp(mem_rsp),
        .outstanding_cnt(outstanding_cnt), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic mem_pkt_t pkt(input logic [31:0] a, input logic [31:0] d);
        mem_pkt_t p;
        p.addr = a;
        p.data = d;
        p.we   = 1'b0;
        return p;
    endfunction

    // Inputs already driven with mem_req_rdy=1: expect the handshake to go to dst
    task automatic issue(input bit dst, input logic [31:0] addr);
        settle();
        chk("req_vld", 64'(mem_req_vld), 64'd1);
        chk("req_addr", 64'(mem_req.addr), 64'(addr));
        chk("imem_req_rdy", 64'(imem_req_rdy), 64'(!dst));
        chk("dmem_req_rdy", 64'(dmem_req_rdy), 64'(dst));
        exp_q.push_back(dst);
        last_g = dst;
        tick();
    endtask

    // Present one memory response and check it lands at the queued requester
    task automatic respond(input logic [31:0] data);
        bit dst;
        mem_rsp_vld  = 1'b1;
        mem_rsp      = pkt(32'h0, data);
        imem_rsp_rdy = 1'b1;
        dmem_rsp_rdy = 1'b1;
        settle();
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL sb_underflow observed=response expected=none");
        end else begin
            dst = exp_q.pop_front();
            chk("imem_rsp_vld", 64'(imem_rsp_vld), 64'(!dst));
            chk("dmem_rsp_vld", 64'(dmem_rsp_vld), 64'(dst));
            chk("rsp_data", 64'(dst ? dmem_rsp.data : imem_rsp.data), 64'(data));
            chk("mem_rsp_rdy", 64'(mem_rsp_rdy), 64'd1);
        end
    endtask

    task automatic drain(input logic [31:0] data);
        respond(data);
        tick();
        mem_rsp_vld = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        imem_req_vld = 1'b1; dmem_req_vld = 1'b0;
        imem_req = pkt(32'h0, 32'h0); dmem_req = pkt(32'h0, 32'h0);
        imem_rsp_rdy = 1'b1; dmem_rsp_rdy = 1'b1;
        mem_req_rdy = 1'b1; mem_rsp_vld = 1'b0; mem_rsp = pkt(32'h0, 32'h0);
        last_g = 1'b1;
        #3;
        chk("rst_mem_req_vld", 64'(mem_req_vld), 64'd0);
        chk("rst_imem_rsp_vld", 64'(imem_rsp_vld), 64'd0);
        chk("rst_dmem_rsp_vld", 64'(dmem_rsp_vld), 64'd0);
        chk("rst_cnt", 64'(outstanding_cnt), 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);
        imem_req_vld = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Single fetch, same-cycle pass-through, then its response
        imem_req_vld = 1'b1; imem_req = pkt(32'h100, 32'h0);
        issue(1'b0, 32'h100);
        imem_req_vld = 1'b0;
        chk("cnt_after_fetch", 64'(outstanding_cnt), 64'd1);
        drain(32'hDEADBEEF);
        chk("cnt_after_rsp", 64'(outstanding_cnt), 64'd0);

        // Both requesting: grants alternate
        imem_req_vld = 1'b1; dmem_req_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit w;
            imem_req = pkt(32'h1000 + 32'(i), 32'h0);
            dmem_req = pkt(32'h2000 + 32'(i), 32'h0);
            w = ~last_g;
            issue(w, w ? 32'h2000 + 32'(i) : 32'h1000 + 32'(i));
        end
        imem_req_vld = 1'b0; dmem_req_vld = 1'b0;
        chk("cnt_rr", 64'(outstanding_cnt), 64'd4);
        drain(32'hA); drain(32'hB); drain(32'hC); drain(32'hD);

        // Lone dmem request leaves last_grant at dmem
        dmem_req_vld = 1'b1; dmem_req = pkt(32'h3000, 32'h0);
        issue(1'b1, 32'h3000);
        dmem_req_vld = 1'b0;
        drain(32'h3333);

        // dmem stalled by memory; imem arrives but the grant stays locked on dmem
        mem_req_rdy = 1'b0;
        dmem_req_vld = 1'b1; dmem_req = pkt(32'h4000, 32'h0);
        settle();
        chk("lock_vld", 64'(mem_req_vld), 64'd1);
        chk("lock_addr", 64'(mem_req.addr), 64'h4000);
        chk("lock_dmem_rdy", 64'(dmem_req_rdy), 64'd0);
        tick();
        imem_req_vld = 1'b1; imem_req = pkt(32'h5000, 32'h0);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("lock_hold_addr", 64'(mem_req.addr), 64'h4000);
            chk("lock_imem_rdy", 64'(imem_req_rdy), 64'd0);
            tick();
        end
        mem_req_rdy = 1'b1;
        issue(1'b1, 32'h4000);
        dmem_req_vld = 1'b0;
        issue(1'b0, 32'h5000);
        imem_req_vld = 1'b0;
        chk("cnt_lock", 64'(outstanding_cnt), 64'd2);
        drain(32'h4444); drain(32'h5555);

        // Fill the FIFO; the fifth request waits until a pop has registered
        imem_req_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_req = pkt(32'h6000 + 32'(i), 32'h0);
            issue(1'b0, 32'h6000 + 32'(i));
        end
        imem_req = pkt(32'h6004, 32'h0);
        settle();
        chk("full_cnt", 64'(outstanding_cnt), 64'd4);
        chk("full_req_vld", 64'(mem_req_vld), 64'd0);
        chk("full_imem_rdy", 64'(imem_req_rdy), 64'd0);
        tick();
        respond(32'h6000);
        chk("full_no_bypass", 64'(mem_req_vld), 64'd0);
        tick();
        mem_rsp_vld = 1'b0;
        chk("full_cnt_pop", 64'(outstanding_cnt), 64'd3);
        issue(1'b0, 32'h6004);
        imem_req_vld = 1'b0;
        chk("full_cnt_refill", 64'(outstanding_cnt), 64'd4);
        drain(32'h6001); drain(32'h6002); drain(32'h6003); drain(32'h6004);

        // Response back-pressure from imem holds the FIFO head
        imem_req_vld = 1'b1; imem_req = pkt(32'h7000, 32'h0);
        issue(1'b0, 32'h7000);
        imem_req_vld = 1'b0;
        mem_rsp_vld = 1'b1; mem_rsp = pkt(32'h0, 32'hCAFE0007); imem_rsp_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("bp_imem_vld", 64'(imem_rsp_vld), 64'd1);
            chk("bp_mem_rsp_rdy", 64'(mem_rsp_rdy), 64'd0);
            tick();
            chk("bp_cnt_held", 64'(outstanding_cnt), 64'd1);
        end
        drain(32'hCAFE0007);
        chk("bp_cnt_done", 64'(outstanding_cnt), 64'd0);
        settle();
        chk("bp_once", 64'(imem_rsp_vld), 64'd0);
        tick();

        // Response with nothing outstanding is drained and flagged
        mem_rsp_vld = 1'b1; mem_rsp = pkt(32'h0, 32'hBAD);
        settle();
        chk("orphan_rdy", 64'(mem_rsp_rdy), 64'd1);
        chk("orphan_imem_vld", 64'(imem_rsp_vld), 64'd0);
        chk("orphan_dmem_vld", 64'(dmem_rsp_vld), 64'd0);
        chk("orphan_err_pre", 64'(rsp_err), 64'd0);
        tick();
        mem_rsp_vld = 1'b0;
        chk("orphan_err", 64'(rsp_err), 64'd1);
        tick();
        chk("orphan_err_sticky", 64'(rsp_err), 64'd1);

        // Asynchronous reset with two requests outstanding
        imem_req_vld = 1'b1;
        imem_req = pkt(32'h8000, 32'h0); issue(1'b0, 32'h8000);
        imem_req = pkt(32'h8001, 32'h0); issue(1'b0, 32'h8001);
        chk("pre_rst_cnt", 64'(outstanding_cnt), 64'd2);
        #1 rst = 1'b1;
        #1;
        chk("arst_cnt", 64'(outstanding_cnt), 64'd0);
        chk("arst_err", 64'(rsp_err), 64'd0);
        chk("arst_req_vld", 64'(mem_req_vld), 64'd0);
        chk("arst_imem_rdy", 64'(imem_req_rdy), 64'd0);
        exp_q.delete();
        imem_req_vld = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // A late response for a discarded tag is an error
        mem_rsp_vld = 1'b1; mem_rsp = pkt(32'h0, 32'h8000);
        settle();
        chk("late_imem_vld", 64'(imem_rsp_vld), 64'd0);
        chk("late_rdy", 64'(mem_rsp_rdy), 64'd1);
        tick();
        mem_rsp_vld = 1'b0;
        chk("late_err", 64'(rsp_err), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the core's imem (fetch) and dmem (load/store) request/response channels.
- Arbitrates requests round-robin and holds a grant stable until the memory accepts it.
- Records the source of every accepted request in an in-order outstanding-tag FIFO, then routes each memory response back to the requester that issued it.
- Sits between core and the single-ported memory model/cache; all channels use the mem_pkt_t valid/ready handshake.

Parameters:
- MAX_OUTSTANDING, 4, depth of the outstanding-tag FIFO (power of 2, >=2).
- CNT_W, $clog2(MAX_OUTSTANDING)+1, width of the occupancy counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req_vld  input  1  fetch request valid.
- imem_req_rdy  output  1  fetch request accepted this cycle.
- imem_req  input  mem_pkt_t  fetch request packet.
- imem_rsp_vld  output  1  fetch response valid.
- imem_rsp_rdy  input  1  core ready for fetch response.
- imem_rsp  output  mem_pkt_t  fetch response packet.
- dmem_req_vld  input  1  data request valid.
- dmem_req_rdy  output  1  data request accepted.
- dmem_req  input  mem_pkt_t  data request packet.
- dmem_rsp_vld  output  1  data response valid.
- dmem_rsp_rdy  input  1  core ready for data response.
- dmem_rsp  output  mem_pkt_t  data response packet.
- mem_req_vld  output  1  request to memory valid.
- mem_req_rdy  input  1  memory accepts request.
- mem_req  output  mem_pkt_t  muxed request packet.
- mem_rsp_vld  input  1  memory response valid.
- mem_rsp_rdy  output  1  arbiter accepts response.
- mem_rsp  input  mem_pkt_t  memory response packet.
- outstanding_cnt  output  CNT_W  number of accepted, unanswered requests.
- rsp_err  output  1  sticky: a response arrived with no outstanding request.

Behaviour:
- Reset (rst high, asynchronous): FIFO empty, outstanding_cnt=0, rsp_err=0, lock=0, last_grant=DMEM (so imem wins the first tie). mem_req_vld=0, imem_rsp_vld=0 and dmem_rsp_vld=0 while rst is asserted. Reset mid-transaction discards all outstanding tags; late memory responses after reset set rsp_err.
- Arbiter states:
  - IDLE (lock=0): grant is combinational from the valids.
    - Only one requester valid -> that requester wins.
    - Both valid -> the requester that is not last_grant wins.
  - LOCKED (lock=1): grant held at locked_src regardless of the other requester.
- Request path:
  - mem_req_vld = granted requester's vld AND NOT fifo_full.
  - mem_req = granted requester's packet, passed through unmodified.
  - Granted requester's req_rdy = mem_req_rdy AND NOT fifo_full. The other requester's req_rdy=0.
  - Zero added latency on the request path.
- Transitions:
  - IDLE -> LOCKED when mem_req_vld=1 and mem_req_rdy=0. locked_src = current grant.
  - LOCKED -> IDLE on the handshake (mem_req_vld & mem_req_rdy).
  - Any handshake updates last_grant = granted source and pushes the source tag (0=imem, 1=dmem) into the FIFO.
- FIFO full: mem_req_vld is forced low and lock is unchanged. Push is blocked even if a pop occurs in the same cycle (no full bypass).
- Response path (in-order memory assumed):
  - FIFO non-empty: head tag selects the destination.
    - dest_rsp_vld = mem_rsp_vld; dest_rsp = mem_rsp.
    - mem_rsp_rdy = dest_rsp_rdy.
    - The other rsp_vld = 0.
    - Pop on mem_rsp_vld & mem_rsp_rdy.
  - FIFO empty: mem_rsp_rdy=1 (the response is drained and dropped), both rsp_vld=0, rsp_err set if mem_rsp_vld=1.
- Simultaneous push and pop (not full): occupancy unchanged; pointers both advance and wrap modulo MAX_OUTSTANDING.
- outstanding_cnt = registered occupancy, 0..MAX_OUTSTANDING.
- rsp_err clears only on reset.

Test Plan:
- Reset, then only imem_req_vld=1 with addr 0x100 and mem_req_rdy=1 -> same-cycle mem_req.addr=0x100 and imem_req_rdy=1; cnt 0->1. Response data 0xDEADBEEF -> imem_rsp_vld=1 with data 0xDEADBEEF, dmem_rsp_vld=0; cnt->0.
- Both valid continuously, mem_req_rdy=1 -> grants alternate imem, dmem, imem, dmem. In-order responses A,B,C,D go to imem, dmem, imem, dmem respectively.
- dmem granted while mem_req_rdy=0 for 3 cycles, then imem asserts -> mem_req stays dmem's packet and imem_req_rdy=0 until the dmem handshake. The next grant goes to imem.
- Issue 4 requests with no responses (MAX_OUTSTANDING=4) -> cnt=4 and mem_req_vld=0 with a 5th pending. One response pops -> the 5th issues the following cycle; cnt returns to 4.
- Response tagged imem with imem_rsp_rdy=0 for 2 cycles -> mem_rsp_rdy=0 and the FIFO head is held. Rdy=1 -> single pop, data delivered once.
- mem_rsp_vld=1 with the FIFO empty -> mem_rsp_rdy=1, no rsp_vld, rsp_err=1 sticky. Assert rst mid-stream with cnt=2 -> cnt=0, rsp_err=0, outputs low immediately.
